// File: rtl/bnn_param_loader.sv
// Parameter loader for a daisy-chained binary neuron array.
// Serializes a byte stream MSB-first onto the chain, strobing setup per bit.
module bnn_param_loader #(
  parameter int NEURONS   = 4,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       setup,
  output logic       param_out,
  output logic       busy,
  output logic       loaded
);

  localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int NUM_BYTES  = (TOTAL_BITS + 7) / 8;
  localparam int BW         = $clog2(TOTAL_BITS + 1);
  localparam int CW         = $clog2(NUM_BYTES + 1);

  localparam logic [BW-1:0] TOT  = BW'(TOTAL_BITS);
  localparam logic [BW-1:0] LAST = BW'(TOTAL_BITS - 1);
  localparam logic [CW-1:0] NB   = CW'(NUM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

  state_e        state_q;
  logic          busy_q;
  logic          loaded_q;
  logic [7:0]    byte_q;
  logic          have_q;
  logic [2:0]    idx_q;
  logic [CW-1:0] bytes_q;
  logic [BW-1:0] bits_q;

  logic in_load;
  logic setup_w;
  logic ready_w;
  logic accept_w;
  logic last_w;

  assign in_load = (state_q == LOAD);
  assign setup_w = in_load & have_q & (bits_q < TOT);

  // A new byte may land on the same cycle the old one shifts its bit 0.
  assign ready_w = in_load & (bytes_q < NB)
                 & (~have_q | (setup_w & (idx_q == 3'd7)));

  assign accept_w = in_valid & ready_w & ~start;
  assign last_w   = setup_w & (bits_q == LAST);

  assign in_ready  = ready_w;
  assign setup     = setup_w;
  assign param_out = setup_w ? byte_q[3'd7 - idx_q] : 1'b0;
  assign busy      = busy_q;
  assign loaded    = loaded_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
      byte_q   <= 8'd0;
      have_q   <= 1'b0;
      idx_q    <= 3'd0;
      bytes_q  <= '0;
      bits_q   <= '0;
    end else if (start) begin
      // Start from any state (re)opens a clean load; a partial byte is dropped.
      state_q  <= LOAD;
      busy_q   <= 1'b1;
      loaded_q <= 1'b0;
      have_q   <= 1'b0;
      idx_q    <= 3'd0;
      bytes_q  <= '0;
      bits_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        LOAD: begin
          if (setup_w) begin
            bits_q <= bits_q + BW'(1);
            idx_q  <= idx_q + 3'd1;
            if (idx_q == 3'd7) have_q <= 1'b0;
          end
          if (accept_w) begin
            byte_q  <= in_data;
            have_q  <= 1'b1;
            idx_q   <= 3'd0;
            bytes_q <= bytes_q + CW'(1);
          end
          // Pad bits at the tail of the final byte are never shifted.
          if (last_w) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            loaded_q <= 1'b1;
            have_q   <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          loaded_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Sequences the weight/bias configuration of a daisy-chained array of binary neurons. Accepts parameter bytes over a valid/ready stream, serializes them MSB-first onto the chain's serial parameter input, and drives the chain's `setup` strobe only on cycles that carry a valid bit. Raises `loaded` once exactly `NEURONS*(INPUTS+BIAS_BITS)` bits have been shifted. Sits between the host/config port and the neuron array.

## Interface

- `NEURONS`, 4, number of neurons in the chain
- `INPUTS`, 8, weight bits per neuron
- `BIAS_BITS`, 3, bias bits per neuron
- Derived, not overridable: `TOTAL_BITS = NEURONS*(INPUTS+BIAS_BITS)`; `NUM_BYTES = ceil(TOTAL_BITS/8)`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse; begins (or restarts) a load
- `in_data`  in  8  parameter byte, bit 7 shifted first
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  byte accepted on a cycle where `in_valid & in_ready`
- `setup`  out  1  to every neuron's `setup`; high only on shift cycles
- `param_out`  out  1  to first neuron's `param_in`
- `busy`  out  1  high in LOAD
- `loaded`  out  1  high in DONE; chain holds a complete parameter set

## Operation

- States: IDLE, LOAD, DONE. Reset → IDLE.
- IDLE: `start` → LOAD. Other inputs ignored.
- LOAD entry (and restart): clear `bytes_acc`, `bits_shifted`, `have_byte`, `bit_idx`.
- Byte register `byte_reg[7:0]`, flag `have_byte`, index `bit_idx` (0..7, 0 = bit 7).
- `in_ready = LOAD & bytes_acc < NUM_BYTES & (!have_byte | (setup & bit_idx==7))` — allows zero-bubble back-to-back bytes.
- Accept: `byte_reg <= in_data`, `have_byte <= 1`, `bit_idx <= 0`, `bytes_acc++`.
- `setup = LOAD & have_byte & bits_shifted < TOTAL_BITS`; `param_out = setup ? byte_reg[7-bit_idx] : 0`.
- Each `setup` cycle: `bits_shifted++`, `bit_idx++`; after bit_idx 7 without a new accept, `have_byte <= 0`.
- When `setup` and `bits_shifted == TOTAL_BITS-1`: → DONE, `have_byte <= 0`. Unused low bits of the final byte (`NUM_BYTES*8 - TOTAL_BITS`) are discarded, never shifted.
- `in_valid` low: no shift, `setup` low, chain holds; shifting resumes on next accepted byte. No timeout.
- DONE: `loaded` high, `in_ready`/`setup` low; `start` → LOAD (clears `loaded`).
- `start` during LOAD: restart; partial byte dropped; chain contents overwritten by the new stream.
- `start` and accept in the same cycle: `start` wins, byte not accepted (`in_ready` already 0 is not required; accept is suppressed and the byte must be re-presented).
- Counter widths: `$clog2(TOTAL_BITS+1)` bits, `$clog2(NUM_BYTES+1)` bits; no wrap reachable.

## Timing

- Reset values: `in_ready=0`, `setup=0`, `param_out=0`, `busy=0`, `loaded=0`.
- `start` at cycle T → `busy` and `in_ready` high at T+1.
- Byte accepted at cycle N → its bit 7 on `param_out` with `setup` high at N+1, bit 0 at N+8.
- Continuous `in_valid`: exactly `TOTAL_BITS` consecutive `setup` cycles; `loaded` high the cycle after the last `setup`.
- Reset mid-LOAD: IDLE next cycle, all outputs at reset values; chain contents undefined (neurons have no reset) until a full reload.

## Test plan

- NEURONS=2, INPUTS=8, BIAS_BITS=3 (22 bits, 3 bytes), bytes 0xA5,0x3C,0xF0 streamed continuously → 22 consecutive `setup` cycles, `param_out` = 10100101 00111100 111100; last 2 bits of 0xF0 dropped; `loaded` at cycle 23 after first accept; `in_ready` low after 3rd byte.
- Same stream with `in_valid` low 5 cycles between bytes 1 and 2 → `setup` low exactly those gap cycles, same bit sequence, `loaded` 5 cycles later.
- `start` after 10 shifted bits, then full new stream 0x00,0xFF,0x80 → 22 shifts of new data only, `loaded` once.
- `reset` asserted mid-LOAD → next cycle all outputs 0, IDLE; further `in_valid` ignored until `start`.
- In DONE, `in_valid` held high → no accept, no `setup`; `start` → `loaded` drops, reload proceeds.
- Behavioural neuron chain model attached: after load, each neuron's weights/bias equal the expected slices of the byte stream.
